hazard_stall_ctrl: RTL

//   Pipeline sequencing controller sitting beside the forwarding unit.
//   - Resolves the hazards forwarding cannot cover: load-use and multi-cycle

---
 rtl/hazard_stall_ctrl_pkg.sv | 39 +++
 rtl/hazard_stall_ctrl_md_busy_timer.sv | 46 ++++
 rtl/hazard_stall_ctrl.sv | 85 ++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: register/NOP constants,
// control modes and the per-mode decode of the pipeline-register enables.
package hazard_stall_ctrl_pkg;

    localparam logic [4:0]  ZERO_REG = 5'd0;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    typedef enum logic [1:0] {CtlNormal, CtlStall, CtlFlush} ctl_mode_e;

    typedef enum logic {StRun, StMdBusy} md_state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic md_issue;
    } ctl_t;

    function automatic ctl_t ctl_decode(input ctl_mode_e mode, input logic md_op);
        ctl_t c;
        c = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
              id_ex_bubble: 1'b0, md_issue: 1'b0};
        unique case (mode)
            CtlFlush: begin
                c.if_id_flush  = 1'b1;
                c.id_ex_bubble = 1'b1;
            end
            CtlStall: begin
                c.pc_write     = 1'b0;
                c.if_id_write  = 1'b0;
                c.id_ex_bubble = 1'b1;
            end
            default: c.md_issue = md_op;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_timer.sv
// Mult/div occupancy timer: loads MD_LATENCY on issue and counts down to zero;
// busy while the count is non-zero. Stalls and flushes never pause it.
module md_busy_timer
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 32,
    parameter int unsigned MD_CNT_W   = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic busy
);

    localparam logic [MD_CNT_W-1:0] LAT = MD_CNT_W'(MD_LATENCY);

    logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
    md_state_e           state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            md_cnt_q <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

    always_comb begin
        state = (md_cnt_q != '0) ? StMdBusy : StRun;
    end

    // A load while busy cannot occur: the top stalls any mult/div until idle.
    always_comb begin
        md_cnt_d = md_cnt_q;
        unique case (state)
            StRun:    md_cnt_d = load ? LAT : '0;
            StMdBusy: md_cnt_d = md_cnt_q - MD_CNT_W'(1);
            default:  md_cnt_d = '0;
        endcase
    end

    always_comb begin
        busy = (state == StMdBusy);
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use and mult/div hazard stalls, branch flush,
// mult/div busy tracking and a saturating stall-cycle counter.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned MD_LATENCY  = 32,
    parameter int unsigned MD_CNT_W    = 6,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             id_instr_rs,
    input  logic [4:0]             id_instr_rt,
    input  logic                   id_uses_rs,
    input  logic                   id_uses_rt,
    input  logic                   id_md_op,
    input  logic                   id_reads_hilo,
    input  logic                   id_ex_mem_read,
    input  logic [4:0]             id_ex_write_reg_addr,
    input  logic                   ex_branch_taken,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   if_id_flush,
    output logic                   id_ex_bubble,
    output logic                   md_issue,
    output logic                   md_busy,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    logic                   lu_haz, md_haz, stall;
    ctl_mode_e              mode;
    ctl_t                   ctl;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        lu_haz = id_ex_mem_read && (id_ex_write_reg_addr != ZERO_REG)
                 && ((id_uses_rs && (id_ex_write_reg_addr == id_instr_rs))
                     || (id_uses_rt && (id_ex_write_reg_addr == id_instr_rt)));
        md_haz = md_busy && (id_md_op || id_reads_hilo);
        stall  = !ex_branch_taken && (lu_haz || md_haz);

        if (ex_branch_taken) begin
            mode = CtlFlush;
        end else if (stall) begin
            mode = CtlStall;
        end else begin
            mode = CtlNormal;
        end

        ctl          = ctl_decode(mode, id_md_op);
        pc_write     = ctl.pc_write;
        if_id_write  = ctl.if_id_write;
        if_id_flush  = ctl.if_id_flush;
        id_ex_bubble = ctl.id_ex_bubble;
        md_issue     = ctl.md_issue;
    end

    md_busy_timer #(
        .MD_LATENCY (MD_LATENCY),
        .MD_CNT_W   (MD_CNT_W)
    ) u_md_busy_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (md_issue),
        .busy  (md_busy)
    );

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;

endmodule
